// File: rtl/param_sync_fifo_pkg.sv
// Shared types and width/pointer helpers for the parameterised synchronous FIFO.
package fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Compare-based wrap so non-power-of-two depths never alias through overflow.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned last);
    return (ptr == last) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Valid/ready handshake bundle for both FIFO sides; master is the environment, slave is the FIFO.
interface param_sync_fifo_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/param_sync_fifo_ptr.sv
// Wrapping pointer register with enable; wraps from LAST back to zero.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned PW   = 4,
  parameter int unsigned LAST = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= PW'(ptr_next(32'(ptr), LAST));
    end
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous first-word-fall-through FIFO with valid/ready on both sides.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 16,
  parameter int unsigned      ARRAY_SIZE  = WIDTH * DEPTH,
  parameter int unsigned      OFFSET      = DEPTH - 1,
  parameter int unsigned      AFULL_LEVEL = DEPTH - 2,
  parameter logic [WIDTH-1:0] RESET_DATA  = {WIDTH{1'b0}},
  parameter string            NAME        = "fifo"
) (
  input  logic                        clk,
  input  logic                        rst,
  param_sync_fifo_if.slave            bus,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        almost_full
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  if (ARRAY_SIZE != WIDTH * DEPTH) begin : g_array_size_check
    $error("%s: ARRAY_SIZE is derived and must not be overridden", NAME);
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count_nxt;
  fifo_op_e         op;

  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);

  // Handshakes presented during the reset cycle must leave no trace.
  assign push = bus.in_valid  & bus.in_ready  & ~rst;
  assign pop  = bus.out_valid & bus.out_ready & ~rst;

  fifo_ptr #(.PW(PW), .LAST(OFFSET)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (push),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.PW(PW), .LAST(OFFSET)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (pop),
    .ptr (rd_ptr)
  );

  always_comb begin
    op        = fifo_op_e'({push, pop});
    count_nxt = count;
    case (op)
      OP_PUSH: count_nxt = count + CW'(1);
      OP_POP:  count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_nxt;
      almost_full <= (count_nxt >= CW'(AFULL_LEVEL));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  assign bus.out_data = bus.out_valid ? mem[rd_ptr] : RESET_DATA;

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && count == CW'(DEPTH)))
    else $error("%s: push while full", NAME);

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && count == '0))
    else $error("%s: pop while empty", NAME);

  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count <= CW'(DEPTH))
    else $error("%s: count exceeds DEPTH", NAME);

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=> $stable(bus.out_data))
    else $error("%s: out_data changed while stalled", NAME);
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench: DEPTH=16/WIDTH=8 and DEPTH=5/WIDTH=12 instances.
module tb_param_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_sync_fifo_if #(.WIDTH(8))  bus_a ();
  param_sync_fifo_if #(.WIDTH(12)) bus_b ();

  logic [4:0] count_a;
  logic [2:0] count_b;
  logic       afull_a;
  logic       afull_b;

  param_sync_fifo #(.WIDTH(8), .DEPTH(16), .NAME("fifo_a")) dut_a (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_a.slave),
    .count       (count_a),
    .almost_full (afull_a)
  );

  param_sync_fifo #(.WIDTH(12), .DEPTH(5), .NAME("fifo_b")) dut_b (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_b.slave),
    .count       (count_b),
    .almost_full (afull_b)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [7:0]  q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = '0;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_b.in_data   = '0;
    bus_b.out_ready = 1'b0;

    // Reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_count",     32'(count_a),         0);
    check("rst_out_valid", 32'(bus_a.out_valid), 0);
    check("rst_in_ready",  32'(bus_a.in_ready),  1);
    check("rst_out_data",  32'(bus_a.out_data),  0);
    check("rst_afull",     32'(afull_a),         0);
    tick();
    check("idle_count",    32'(count_a),         0);

    // Fill to full
    for (int i = 0; i < 16; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 8'(i + 1);
      tick();
      check("fill_count", 32'(count_a), 32'(i + 1));
      check("fill_afull", 32'(afull_a), (i + 1 >= 14) ? 1 : 0);
    end
    check("full_in_ready",  32'(bus_a.in_ready), 0);
    bus_a.in_data = 8'hFF;
    tick();
    check("over_count",     32'(count_a),        16);
    check("over_head",      32'(bus_a.out_data), 32'h01);
    bus_a.in_valid = 1'b0;

    // Drain order
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", 32'(bus_a.out_valid), 1);
      check("drain_data",  32'(bus_a.out_data),  32'(i + 1));
      tick();
    end
    bus_a.out_ready = 1'b0;
    check("drain_end_valid", 32'(bus_a.out_valid), 0);
    check("drain_end_count", 32'(count_a),         0);
    check("drain_end_data",  32'(bus_a.out_data),  0);

    // Simultaneous push/pop at count=5, pointers wrap past 15
    q.delete();
    for (int i = 0; i < 5; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 8'(8'h20 + i);
      q.push_back(8'(8'h20 + i));
      tick();
    end
    check("pre_stream_count", 32'(count_a), 5);
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus_a.in_data = 8'(8'h25 + i);
      check("stream_data", 32'(bus_a.out_data), 32'(q[0]));
      tick();
      void'(q.pop_front());
      q.push_back(8'(8'h25 + i));
      check("stream_count", 32'(count_a), 5);
    end
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_data = 8'(8'h40 + i);
      tick();
    end
    bus_a.in_valid = 1'b0;
    check("pre_reset_count", 32'(count_a),         9);
    check("pre_reset_head",  32'(bus_a.out_data),  32'h34);

    // Reset mid-operation with both handshakes offered
    rst             = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 8'h99;
    bus_a.out_ready = 1'b1;
    tick();
    rst             = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b0;
    check("mid_rst_count",     32'(count_a),         0);
    check("mid_rst_out_valid", 32'(bus_a.out_valid), 0);
    check("mid_rst_in_ready",  32'(bus_a.in_ready),  1);
    check("mid_rst_out_data",  32'(bus_a.out_data),  0);
    tick();
    check("post_rst_count",    32'(count_a),         0);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h77;
    tick();
    bus_a.in_valid = 1'b0;
    check("post_rst_push_count", 32'(count_a),        1);
    check("post_rst_push_data",  32'(bus_a.out_data), 32'h77);

    // Non-power-of-two depth: DEPTH=5, WIDTH=12
    for (int i = 0; i < 5; i++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = 12'(12'hA00 + i);
      tick();
    end
    bus_b.in_valid = 1'b0;
    check("b_full_count",    32'(count_b),          5);
    check("b_full_in_ready", 32'(bus_b.in_ready),   0);
    check("b_wr_wrap",       32'(dut_b.wr_ptr),     0);
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("b_pop_data", 32'(bus_b.out_data), 32'(12'hA00 + i));
      tick();
    end
    bus_b.out_ready = 1'b0;
    check("b_mid_count", 32'(count_b), 2);
    for (int i = 0; i < 3; i++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = 12'(12'hA05 + i);
      tick();
    end
    bus_b.in_valid = 1'b0;
    check("b_refill_count", 32'(count_b),      5);
    check("b_wr_ptr",       32'(dut_b.wr_ptr), 3);
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("b_drain_data", 32'(bus_b.out_data), 32'(12'hA03 + i));
      tick();
    end
    bus_b.out_ready = 1'b0;
    check("b_empty_valid", 32'(bus_b.out_valid), 0);
    check("b_empty_data",  32'(bus_b.out_data),  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
